// File: rtl/mem_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_master : CPU-side initiator for the 2048x8 synchronous data RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_master #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_data0,
    output logic [DW-1:0] rsp_data1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP0 = 3'd3,
        CAP1 = 3'd4,
        RESP = 3'd5
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;

    state_t        state, state_nxt;
    logic          is_fetch, is_fetch_nxt;
    logic          cmd_ready_nxt;
    logic          rsp_valid_nxt;
    logic          rsp_err_nxt;
    logic [DW-1:0] rsp_data0_nxt;
    logic [DW-1:0] rsp_data1_nxt;
    logic          mem_wr_en_nxt;
    logic [AW-1:0] mem_address_nxt;
    logic [DW-1:0] mem_wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_fetch    <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data0   <= '0;
            rsp_data1   <= '0;
            mem_wr_en   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            is_fetch    <= is_fetch_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_data0   <= rsp_data0_nxt;
            rsp_data1   <= rsp_data1_nxt;
            mem_wr_en   <= mem_wr_en_nxt;
            mem_address <= mem_address_nxt;
            mem_wdata   <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        is_fetch_nxt    = is_fetch;
        cmd_ready_nxt   = cmd_ready;
        rsp_valid_nxt   = rsp_valid;
        rsp_err_nxt     = rsp_err;
        rsp_data0_nxt   = rsp_data0;
        rsp_data1_nxt   = rsp_data1;
        mem_wr_en_nxt   = mem_wr_en;
        mem_address_nxt = mem_address;
        mem_wdata_nxt   = mem_wdata;

        case (state)
            IDLE: begin
                // Ready comes up on the first edge out of reset and stays up while idle.
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    case (cmd_op)
                        OP_READ, OP_FETCH: begin
                            mem_address_nxt = cmd_addr;
                            mem_wr_en_nxt   = 1'b0;
                            is_fetch_nxt    = (cmd_op == OP_FETCH);
                            state_nxt       = RD;
                        end
                        OP_WRITE: begin
                            mem_address_nxt = cmd_addr;
                            mem_wdata_nxt   = cmd_wdata;
                            mem_wr_en_nxt   = 1'b1;
                            is_fetch_nxt    = 1'b0;
                            state_nxt       = WR;
                        end
                        default: begin
                            rsp_err_nxt   = 1'b1;
                            rsp_valid_nxt = 1'b1;
                            rsp_data0_nxt = '0;
                            rsp_data1_nxt = '0;
                            is_fetch_nxt  = 1'b0;
                            state_nxt     = RESP;
                        end
                    endcase
                end
            end
            WR: begin
                mem_wr_en_nxt = 1'b0;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                state_nxt     = RESP;
            end
            RD: begin
                // Present addr+1 while the RAM returns the first byte; wraps at the top.
                if (is_fetch) begin
                    mem_address_nxt = mem_address + {{(AW-1){1'b0}}, 1'b1};
                end
                state_nxt = CAP0;
            end
            CAP0: begin
                rsp_data0_nxt = mem_rdata;
                if (is_fetch) begin
                    state_nxt = CAP1;
                end else begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    state_nxt     = RESP;
                end
            end
            CAP1: begin
                rsp_data1_nxt = mem_rdata;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                state_nxt     = RESP;
            end
            RESP: begin
                rsp_valid_nxt = 1'b0;
                rsp_err_nxt   = 1'b0;
                cmd_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_master : scoreboard bench for mem_master with a behavioural 2048x8 RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_master;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_data0;
    logic [DW-1:0] rsp_data1;
    logic          mem_wr_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_master #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_data0   (rsp_data0),
        .rsp_data1   (rsp_data1),
        .mem_wr_en   (mem_wr_en),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, cleared by the shared reset.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else if (mem_wr_en) begin
            ram[mem_address] <= mem_wdata;
        end else begin
            mem_rdata <= ram[mem_address];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] prev;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            acc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] hold_d0, hold_d1;
    logic [AW-1:0] last_addr;
    int            cyc = 0;
    int            wr_cnt = 0;
    bit            up = 0;

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    // Inputs change at posedge+2, so the falling edge sees a stable cycle.
    always @(negedge clk) begin
        exp_t          f;
        exp_t          e;
        int            k;
        logic [AW-1:0] a1;
        cyc++;
        if (!rst_n) begin
            check("reset_outputs",
                  {cmd_ready, rsp_valid, rsp_err, rsp_data0, rsp_data1, mem_wr_en, mem_address, mem_wdata},
                  64'd0);
            q.delete();
            for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
            hold_d0   = '0;
            hold_d1   = '0;
            last_addr = '0;
            wr_cnt    = 0;
            up        = 0;
        end else begin
            check("cmd_ready", cmd_ready, (up && q.size() == 0));
            up = 1;
            if (q.size() != 0) begin
                f  = q[0];
                k  = cyc - f.acc;
                a1 = f.addr + 11'd1;
                if (f.op[0] == 1'b0 && k == 1) check("rd_addr", mem_address, f.addr);
                if (f.op == 2'b10 && k == 2)   check("fetch_addr1", mem_address, a1);
                if (f.op == 2'b11 && k == 1)   check("illegal_addr_kept", mem_address, f.prev);
            end
            if (mem_wr_en) begin
                wr_cnt++;
                if (q.size() != 0) begin
                    check("wr_addr", mem_address, q[0].addr);
                    check("wr_data", mem_wdata, q[0].wdata);
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    f = q.pop_front();
                    check("rsp_err", rsp_err, (f.op == 2'b11));
                    check("rsp_data0", rsp_data0, f.d0);
                    check("rsp_data1", rsp_data1, f.d1);
                    check("latency", cyc - f.acc, exp_lat(f.op));
                    check("wr_en_cycles", wr_cnt, (f.op == 2'b01) ? 1 : 0);
                end
                wr_cnt = 0;
            end
            if (cmd_valid && cmd_ready) begin
                e.op    = cmd_op;
                e.addr  = cmd_addr;
                e.wdata = cmd_wdata;
                e.prev  = last_addr;
                e.acc   = cyc;
                a1      = cmd_addr + 11'd1;
                case (cmd_op)
                    2'b00: begin hold_d0 = ref_mem[cmd_addr]; last_addr = cmd_addr; end
                    2'b01: begin ref_mem[cmd_addr] = cmd_wdata; last_addr = cmd_addr; end
                    2'b10: begin
                        hold_d0   = ref_mem[cmd_addr];
                        hold_d1   = ref_mem[a1];
                        last_addr = a1;
                    end
                    default: begin hold_d0 = '0; hold_d1 = '0; end
                endcase
                e.d0 = hold_d0;
                e.d1 = hold_d1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves cmd_valid high; the caller decides whether to chain another command.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 0, 1);
        tick();
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        while (q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        tick();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] pick [4];
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        send(2'b01, 11'h005, 8'hA5);
        drain();
        send(2'b00, 11'h005, 8'h00);
        drain();

        send(2'b01, 11'h7FF, 8'h11);
        send(2'b01, 11'h000, 8'h22);
        drain();
        send(2'b10, 11'h7FF, 8'h00);
        drain();

        send(2'b11, 11'h010, 8'hEE);
        drain();

        send(2'b00, 11'h005, 8'h00);
        send(2'b01, 11'h100, 8'h5A);
        send(2'b10, 11'h0FF, 8'h00);
        send(2'b00, 11'h100, 8'h00);
        send(2'b11, 11'h123, 8'h00);
        send(2'b10, 11'h7FF, 8'h00);
        drain();

        send(2'b00, 11'h7FF, 8'h00);
        send(2'b01, 11'h020, 8'h33);
        drain();

        pick[0] = 11'h7FE; pick[1] = 11'h7FF; pick[2] = 11'h000; pick[3] = 11'h001;
        for (int i = 0; i < 24; i++) begin
            send(2'($urandom_range(0, 3)), pick[$urandom_range(0, 3)], 8'($urandom_range(0, 255)));
        end
        drain();

        send(2'b10, 11'h005, 8'h00);
        cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        send(2'b00, 11'h005, 8'h00);
        send(2'b10, 11'h7FF, 8'h00);
        drain();

        do_reset();
        send(2'b00, 11'h020, 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
